// File: rtl/backbone_pkg.sv
// Shared widths, clear-FSM encoding and the saturating adder used by the
// conv1 C-buffer accumulate path.
package backbone_pkg;

    localparam int ACC_W  = 32;
    localparam int PSUM_W = 24;
    localparam int ADDR_W = 32;
    localparam int SAT_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2
    } clr_state_e;

    // Adds two sign-extended operands and clamps to a w-bit signed range.
    function automatic logic [SAT_W-1:0] sat_add(
        input  logic [SAT_W-1:0] a,
        input  logic [SAT_W-1:0] b,
        input  int               w,
        output logic             sat
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] mx;
        logic signed [SAT_W:0] mn;
        logic signed [SAT_W:0] one;
        one = {{SAT_W{1'b0}}, 1'b1};
        s   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        mx  = (one <<< (w - 1)) - one;
        mn  = -mx - one;
        sat = 1'b0;
        if (s > mx) begin
            sat = 1'b1;
            s   = mx;
        end else if (s < mn) begin
            sat = 1'b1;
            s   = mn;
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/conv1_c_accum_rmw_if.sv
// Update stream plus accumulator-BRAM port of the C-buffer read-modify-write block.
interface conv1_c_accum_rmw_if
    import backbone_pkg::*;
#(
    parameter int PS_W    = PSUM_W,
    parameter int ACC_W_P = ACC_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_W-1:0]         in_addr;
    logic signed [PS_W-1:0]    in_data;
    logic                      in_first;

    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [ACC_W_P-1:0] rd_data;
    logic                      rd_valid;

    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic signed [ACC_W_P-1:0] wr_data;
    logic                      clear_all;

    modport slave (
        input  in_valid, in_addr, in_data, in_first, rd_data, rd_valid,
        output in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, clear_all
    );

    modport master (
        output in_valid, in_addr, in_data, in_first, rd_data, rd_valid,
        input  in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, clear_all
    );

endinterface

// File: rtl/conv1_c_rmw_pipe.sv
// Read-modify-write datapath: S1 (old value select + saturating add), W (write)
// and W_d (one-cycle echo of W that covers the BRAM read-during-write window).
module conv1_c_rmw_pipe
    import backbone_pkg::*;
#(
    parameter int ACC_W_P = ACC_W,
    parameter int PS_W    = PSUM_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      acc_vld_i,
    input  logic [ADDR_W-1:0]         acc_addr_i,
    input  logic signed [PS_W-1:0]    acc_data_i,
    input  logic                      acc_first_i,
    input  logic signed [ACC_W_P-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      wr_en_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic signed [ACC_W_P-1:0] wr_data_o,
    output logic                      empty_o,
    output logic                      sat_o,
    output logic                      proto_o
);

    typedef struct packed {
        logic              vld;
        logic              first;
        logic [ADDR_W-1:0] addr;
        logic [PS_W-1:0]   data;
    } s1_t;

    typedef struct packed {
        logic               vld;
        logic [ADDR_W-1:0]  addr;
        logic [ACC_W_P-1:0] data;
    } w_t;

    s1_t                s1_q;
    w_t                 w_q;
    w_t                 wd_q;
    w_t                 w_d;
    logic [ACC_W_P-1:0] old_val;
    logic [ACC_W_P-1:0] base_val;
    logic [SAT_W-1:0]   sum_full;
    logic               sat;

    always_comb begin
        // Youngest in-flight result wins; BRAM data may predate the last two writes.
        if (w_q.vld && (w_q.addr == s1_q.addr)) begin
            old_val = w_q.data;
        end else if (wd_q.vld && (wd_q.addr == s1_q.addr)) begin
            old_val = wd_q.data;
        end else begin
            old_val = rd_data_i;
        end
        base_val = s1_q.first ? '0 : old_val;
        sat      = 1'b0;
        sum_full = sat_add({{(SAT_W-ACC_W_P){base_val[ACC_W_P-1]}}, base_val},
                           {{(SAT_W-PS_W){s1_q.data[PS_W-1]}}, s1_q.data},
                           ACC_W_P, sat);
        w_d.vld  = s1_q.vld;
        w_d.addr = s1_q.addr;
        w_d.data = sum_full[ACC_W_P-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            w_q  <= '0;
            wd_q <= '0;
        end else begin
            s1_q <= '{vld: acc_vld_i, first: acc_first_i, addr: acc_addr_i, data: acc_data_i};
            w_q  <= w_d;
            wd_q <= w_q;
        end
    end

    assign wr_en_o   = w_q.vld;
    assign wr_addr_o = w_q.addr;
    assign wr_data_o = w_q.data;
    assign empty_o   = !(s1_q.vld || w_q.vld || wd_q.vld);
    assign sat_o     = s1_q.vld && sat;
    assign proto_o   = s1_q.vld && !rd_valid_i;

endmodule

// File: rtl/conv1_c_accum_rmw.sv
// C-buffer accumulator: one partial-sum update per cycle into BRAM, plus a
// drain-then-clear sequencer and sticky saturation / protocol flags.
module conv1_c_accum_rmw
    import backbone_pkg::*;
#(
    parameter int M_TOTAL = 56*56,
    parameter int N_TOTAL = 64,
    parameter int ACC_W_P = ACC_W,
    parameter int PS_W    = PSUM_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    conv1_c_accum_rmw_if.slave   bus,
    output logic                 busy,
    output logic                 sat_flag,
    output logic                 proto_err
);

    // A misconfigured instance never accepts updates instead of corrupting data.
    localparam logic CFG_OK = (M_TOTAL * N_TOTAL > 0) && (PS_W <= ACC_W_P) && (ACC_W_P < SAT_W);

    clr_state_e state_q;
    logic       clear_all_q;
    logic       rdy_q;
    logic       sat_q;
    logic       proto_q;
    logic       pipe_empty;
    logic       sat_pulse;
    logic       proto_pulse;

    assign bus.in_ready  = CFG_OK && rdy_q && (state_q == ST_IDLE) && !clear_req;
    assign bus.rd_en     = bus.in_valid && bus.in_ready;
    assign bus.rd_addr   = bus.in_addr;
    assign bus.clear_all = clear_all_q;
    assign busy          = !pipe_empty || (state_q != ST_IDLE);
    assign sat_flag      = sat_q;
    assign proto_err     = proto_q;

    conv1_c_rmw_pipe #(
        .ACC_W_P (ACC_W_P),
        .PS_W    (PS_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_vld_i   (bus.rd_en),
        .acc_addr_i  (bus.in_addr),
        .acc_data_i  (bus.in_data),
        .acc_first_i (bus.in_first),
        .rd_data_i   (bus.rd_data),
        .rd_valid_i  (bus.rd_valid),
        .wr_en_o     (bus.wr_en),
        .wr_addr_o   (bus.wr_addr),
        .wr_data_o   (bus.wr_data),
        .empty_o     (pipe_empty),
        .sat_o       (sat_pulse),
        .proto_o     (proto_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clear_all_q <= 1'b0;
            rdy_q       <= 1'b0;
            sat_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    clear_all_q <= 1'b0;
                    if (clear_req) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state_q     <= ST_CLR;
                        clear_all_q <= 1'b1;
                    end
                end
                ST_CLR: begin
                    state_q     <= ST_IDLE;
                    clear_all_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    clear_all_q <= 1'b0;
                end
            endcase
            // The buffer is empty once clear_all has been seen, so the flags restart too.
            if (clear_all_q) begin
                sat_q   <= 1'b0;
                proto_q <= 1'b0;
            end else begin
                sat_q   <= sat_q | sat_pulse;
                proto_q <= proto_q | proto_pulse;
            end
        end
    end

endmodule

// File: tb/tb_conv1_c_accum_rmw.sv
// Bench for conv1_c_accum_rmw: BRAM model with read-old-data behaviour, an
// ideal accumulate scoreboard checked every cycle, and directed literal checks.
module tb_conv1_c_accum_rmw;
    import backbone_pkg::*;

    localparam int     AW   = 32;
    localparam int     PW   = 24;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
    localparam longint AMIN = -AMAX - 64'sd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_req = 1'b0;
    logic busy, sat_flag, proto_err;

    conv1_c_accum_rmw_if #(.PS_W(PW), .ACC_W_P(AW)) bus ();

    conv1_c_accum_rmw #(.ACC_W_P(AW), .PS_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .bus       (bus),
        .busy      (busy),
        .sat_flag  (sat_flag),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // BRAM: 1-cycle read latency, a read in the same cycle as a write returns old data.
    longint mem [longint];
    logic   drop_rv = 1'b0;
    always @(posedge clk) begin
        bus.rd_valid <= bus.rd_en && !drop_rv;
        if (bus.rd_en) bus.rd_data <= mem.exists(bus.rd_addr) ? AW'(mem[bus.rd_addr]) : '0;
        if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
        if (bus.clear_all) mem.delete();
    end

    // Ideal model: every accepted update lands in a plain array instantly and its
    // write must appear exactly two cycles after acceptance.
    typedef struct {
        longint addr;
        longint data;
        int     cyc;
        bit     sat;
        bit     proto;
    } exp_t;

    exp_t   expq[$];
    longint ref_mem [longint];
    longint cmt_mem [longint];
    bit     ref_sat = 1'b0;
    bit     ref_proto = 1'b0;
    int     cyc = 0;
    longint log_a[$];
    longint log_d[$];
    int     log_c[$];
    int     clr_c[$];
    logic   rdy_after_clr = 1'b0;
    bit     prev_clr = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t   e;
        longint a, d, o, s;
        bit     st;
        if (!rst_n) begin
            expq.delete();
            ref_mem   = cmt_mem;
            ref_sat   = 1'b0;
            ref_proto = 1'b0;
            prev_clr  = 1'b0;
            chk("rst_wr_en", bus.wr_en, 0);
            chk("rst_clear_all", bus.clear_all, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", bus.in_ready, 0);
        end else begin
            if (prev_clr) rdy_after_clr = bus.in_ready;
            prev_clr = bus.clear_all;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                chk("wr_en", bus.wr_en, 1);
                chk("wr_addr", bus.wr_addr, e.addr);
                chk("wr_data", bus.wr_data, e.data);
                cmt_mem[e.addr] = e.data;
                if (e.sat) ref_sat = 1'b1;
                if (e.proto) ref_proto = 1'b1;
            end else begin
                chk("wr_idle", bus.wr_en, 0);
            end
            if (bus.wr_en) begin
                log_a.push_back(bus.wr_addr);
                log_d.push_back(bus.wr_data);
                log_c.push_back(cyc);
            end
            chk("sat_flag", sat_flag, ref_sat);
            chk("proto_err", proto_err, ref_proto);
            chk("rd_en", bus.rd_en, bus.in_valid && bus.in_ready);
            if (bus.rd_en) chk("rd_addr", bus.rd_addr, bus.in_addr);
            if (bus.clear_all) begin
                chk("clr_excl", bus.rd_en | bus.wr_en, 0);
                clr_c.push_back(cyc);
                ref_mem.delete();
                cmt_mem.delete();
                ref_sat   = 1'b0;
                ref_proto = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                a  = bus.in_addr;
                d  = bus.in_data;
                o  = ref_mem.exists(a) ? ref_mem[a] : 0;
                s  = bus.in_first ? d : o + d;
                st = 1'b0;
                if (s > AMAX) begin s = AMAX; st = 1'b1; end
                else if (s < AMIN) begin s = AMIN; st = 1'b1; end
                ref_mem[a] = s;
                expq.push_back('{addr: a, data: s, cyc: cyc + 2, sat: st, proto: drop_rv});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint a, input longint d, input bit f);
        bus.in_valid = 1'b1;
        bus.in_addr  = a[31:0];
        bus.in_data  = d[PW-1:0];
        bus.in_first = f;
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clr_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
        clr_c.delete();
    endtask

    task automatic preload(input longint a, input longint v);
        mem[a]     = v;
        ref_mem[a] = v;
        cmt_mem[a] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_first = 1'b0;

        // Reset state
        #12;
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_clear_all", bus.clear_all, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sat", sat_flag, 0);
        chk("reset_proto", proto_err, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", bus.in_ready, 1);

        // Overwrite then add on the same address, back to back
        clr_log();
        send(5, 10, 1);
        send(5, 3, 0);
        idle(4);
        chk("ow_add_count", log_d.size(), 2);
        chk("ow_add_w0", log_d[0], 10);
        chk("ow_add_w1", log_d[1], 13);
        chk("ow_add_addr", log_a[1], 5);
        chk("ow_add_spacing", log_c[1] - log_c[0], 1);

        // Distance-2 hazard
        clr_log();
        send(7, 1, 0);
        send(8, 1, 0);
        send(7, 1, 0);
        idle(4);
        chk("d2_w0", log_d[0], 1);
        chk("d2_w1", log_d[1], 1);
        chk("d2_addr", log_a[2], 7);
        chk("d2_final", log_d[2], 2);

        // Positive saturation
        clr_log();
        preload(20, AMAX - 1);
        send(20, 5, 0);
        idle(4);
        chk("sat_pos_data", log_d[0], 64'sd2147483647);
        chk("sat_pos_flag", sat_flag, 1);

        // Negative saturation
        clr_log();
        preload(21, AMIN + 2);
        send(21, -10, 0);
        idle(4);
        chk("sat_neg_data", log_d[0], -64'sd2147483648);
        chk("sat_neg_flag", sat_flag, 1);

        // Out-of-range address is passed through
        clr_log();
        send(300000, -7, 1);
        send(300000, 2, 0);
        idle(4);
        chk("oob_addr", log_a[1], 300000);
        chk("oob_data", log_d[1], -5);

        // Missing rd_valid sets the protocol flag
        clr_log();
        drop_rv = 1'b1;
        send(25, 9, 1);
        drop_rv = 1'b0;
        idle(4);
        chk("proto_set", proto_err, 1);
        chk("proto_data", log_d[0], 9);

        // Clear with three updates in flight; a repeat request in DRAIN is ignored
        clr_log();
        send(30, 1, 1);
        send(31, 2, 1);
        send(32, 3, 1);
        bus.in_valid = 1'b0;
        clear_req = 1'b1;
        #1;
        chk("clr_req_ready", bus.in_ready, 0);
        tick();
        chk("drain_ready", bus.in_ready, 0);
        tick();
        clear_req = 1'b0;
        idle(8);
        chk("clr_writes", log_d.size(), 3);
        chk("clr_pulses", clr_c.size(), 1);
        chk("clr_delay", clr_c[0] - log_c[2], 3);
        chk("clr_ready_after", rdy_after_clr, 1);
        chk("clr_sat", sat_flag, 0);
        chk("clr_proto", proto_err, 0);
        send(30, 4, 0);
        idle(4);
        chk("clr_mem_zero", log_d[3], 4);

        // Reset during a 4-update burst
        clr_log();
        preload(40, AMAX - 1);
        send(40, 5, 0);
        send(41, 100, 1);
        send(42, 1, 1);
        chk("burst_sat_before", sat_flag, 1);
        chk("burst_first_write", log_d[0], 64'sd2147483647);
        bus.in_valid = 1'b1;
        bus.in_addr  = 43;
        bus.in_data  = 1;
        bus.in_first = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_proto", proto_err, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        repeat (3) tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst2", bus.in_ready, 1);
        chk("burst_log", log_d.size(), 1);
        clr_log();
        send(41, 1, 0);
        idle(4);
        chk("no_partial_write", log_d[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1_c_accum_rmw.md
CONV1_C_ACCUM_RMW -- requirements
Module: conv1_c_accum_rmw

Interface
REQ-001 Parameters: M_TOTAL, default 56*56, output rows; N_TOTAL, default 64, output channels; ACC_W_P, default ACC_W, accumulator width; PS_W, default PSUM_W, partial-sum width, PS_W <= ACC_W_P.
REQ-002 clk  in  1  single clock, all logic on posedge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  partial-sum update offered.
REQ-005 in_ready  out  1  update accepted when in_valid && in_ready.
REQ-006 in_addr  in  int  C buffer address, m*N_TOTAL+n.
REQ-007 in_data  in  PS_W signed  partial sum.
REQ-008 in_first  in  1  1 = overwrite, no add (first K tile).
REQ-009 clear_req  in  1  single-cycle pulse requesting a full buffer clear.
REQ-010 clear_all  out  1  clear strobe to the accumulator BRAM.
REQ-011 rd_en / rd_addr  out  1 / int  BRAM read request.
REQ-012 rd_data / rd_valid  in  ACC_W_P signed / 1  BRAM read return, 1-cycle latency.
REQ-013 wr_en / wr_addr / wr_data  out  1 / int / ACC_W_P signed  BRAM write.
REQ-014 busy  out  1  pipeline non-empty or clear pending.
REQ-015 sat_flag / proto_err  out  1 / 1  sticky saturation flag / sticky missing-rd_valid flag.

Function
REQ-016 rd_en SHALL equal in_valid && in_ready combinationally; rd_addr SHALL equal in_addr.
REQ-017 An accepted update at cycle t SHALL be latched into stage S1 (addr, data, first) at edge t+1.
REQ-018 In cycle t+1, S1 SHALL take rd_data as the old value; proto_err SHALL set if rd_valid=0 while S1 is valid.
REQ-019 Old value forwarding SHALL use the following priority:
- if the W stage is valid with W.addr == S1.addr, use W.data;
- else if the W_d stage is valid with W_d.addr == S1.addr, use W_d.data;
- else use rd_data.
REQ-020 Stage W_d SHALL hold the previous W contents for exactly one cycle.
REQ-021 new = in_first ? sign-extend(data) : old + sign-extend(data), computed at ACC_W_P+1 bits.
REQ-022 new SHALL saturate to the ACC_W_P signed max/min; saturation SHALL set sat_flag.
REQ-023 new SHALL be registered into W at edge t+2, so wr_en=1 and wr_addr/wr_data are valid during cycle t+2.
REQ-024 Throughput SHALL be one update per cycle with no bubbles, including back-to-back updates to the same address.
REQ-025 Clear FSM states: IDLE, DRAIN, CLR.
- IDLE: on clear_req, go to DRAIN.
- DRAIN: in_ready=0; when S1, W and W_d are all empty, go to CLR.
- CLR: clear_all=1 for exactly one cycle, then go to IDLE.
REQ-026 in_ready SHALL be 1 only in IDLE with no clear_req in the same cycle.
REQ-027 A clear_req arriving while the FSM is in DRAIN or CLR SHALL be ignored.
REQ-028 sat_flag and proto_err SHALL be cleared only by reset or by clear_all.
REQ-029 rd_en and wr_en SHALL never both be asserted in the same cycle as clear_all.
REQ-030 Out-of-range addresses (>= M_TOTAL*N_TOTAL) SHALL be passed through unchanged.

Reset
REQ-031 On rst_n low, immediately: S1/W/W_d invalid, FSM=IDLE.
REQ-032 On rst_n low, immediately, these outputs SHALL be 0: wr_en, clear_all, busy, sat_flag and proto_err.
REQ-033 Reset SHALL clear in_ready to 0 while rst_n is low; in_ready returns to 1 on the first cycle after release.
REQ-034 A reset during an update SHALL drop the in-flight updates with no partial write.

Structure
REQ-035 ACC_W, PSUM_W and the sat_add function SHALL live in backbone_pkg.
REQ-036 The RMW datapath (S1, forwarding, saturating add, W, W_d) SHALL be one sub-module, conv1_c_rmw_pipe; the clear FSM and handshake stay in the top level.

Verification
REQ-037 Overwrite then add: addr 5, first=1, data 10, then addr 5, first=0, data 3 in consecutive cycles -> writes 10 then 13 on consecutive cycles.
REQ-038 Distance-2 hazard: addr 7 +1, addr 8 +1, addr 7 +1 starting from 0 -> addr 7 final 2 via W_d forwarding.
REQ-039 Saturation: old = max-1, add +5 -> wr_data = max and sat_flag=1.
REQ-040 Negative saturation: old = min+2, add -10 -> wr_data = min and sat_flag=1.
REQ-041 Clear: clear_req while 3 updates are in flight -> in_ready=0; clear_all pulses once, 3 cycles after the last write; in_ready=1 on the next cycle.
REQ-042 Reset mid-burst: rst_n low during a 4-update stream -> no write after assertion; busy=0; flags=0.
